seq_alu: RTL and testbench

Parametrised multi-cycle signed/unsigned arithmetic unit; successor to the 8-bit Booth datapath. Accepts two W-bit operands and a 2-bit opcode through a valid/ready handshake. Computes add, subtract, radix-2 Booth signed multiply or restoring unsigned divide, and returns a 2W-bit result through a second valid/ready handshake. Sits between an operand-issue stage and a result consumer; one operation in flight.

---
 rtl/seq_alu.sv | 176 +++++++++++++++++
 tb/tb_seq_alu.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Multi-cycle arithmetic unit: add, sub, radix-2 Booth signed multiply, and restoring unsigned divide.
// Operands enter and the 2W-bit result leaves through valid/ready handshakes, with one operation in flight.
module seq_alu #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] res_hi,
    output logic [W-1:0] res_lo,
    output logic         div_by_zero,
    output logic         busy,
    output logic [1:0]   state_o
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready is high only in IDLE, and out_valid is high only in DONE. The result is
    // held stable until it is taken. Neither ready nor valid depends combinationally on
    // the other side.
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);
    localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [W-1:0]  m_q, m_d;        // A: multiplicand / dividend / add operand
    logic [W-1:0]  d_q, d_d;        // B: divisor / add operand
    logic [W:0]    acc_q, acc_d;    // Booth accumulator or partial remainder
    logic [W-1:0]  qr_q, qr_d;      // Booth multiplier or quotient shift register
    logic          qm1_q, qm1_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic          dbz_q, dbz_d;

    logic [W:0]    m_ext, booth_sum, booth_acc, r_sh, r_diff, div_r, addsub;
    logic [W-1:0]  booth_q, div_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            m_q     <= '0;
            d_q     <= '0;
            acc_q   <= '0;
            qr_q    <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            m_q     <= m_d;
            d_q     <= d_d;
            acc_q   <= acc_d;
            qr_q    <= qr_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        m_d     = m_q;
        d_d     = d_q;
        acc_d   = acc_q;
        qr_d    = qr_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;

        m_ext = {m_q[W-1], m_q};
        case ({qr_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + m_ext;
            2'b10:   booth_sum = acc_q - m_ext;
            default: booth_sum = acc_q;
        endcase
        booth_acc = {booth_sum[W], booth_sum[W:1]};
        booth_q   = {booth_sum[0], qr_q[W-1:1]};

        // A remainder below D, shifted left once, still fits in W+1 bits, so bit W is the sign of the trial difference.
        r_sh   = {acc_q[W-1:0], qr_q[W-1]};
        r_diff = r_sh - {1'b0, d_q};
        if (r_diff[W]) begin
            div_r = r_sh;
            div_q = {qr_q[W-2:0], 1'b0};
        end else begin
            div_r = r_diff;
            div_q = {qr_q[W-2:0], 1'b1};
        end

        if (op_q == OP_SUB) addsub = {m_q[W-1], m_q} - {d_q[W-1], d_q};
        else                addsub = {m_q[W-1], m_q} + {d_q[W-1], d_q};

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = CALC;
                    op_d    = op;
                    m_d     = a_in;
                    d_d     = b_in;
                    acc_d   = '0;
                    qr_d    = (op == OP_MUL) ? b_in : a_in;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                case (op_q)
                    OP_MUL: begin
                        acc_d = booth_acc;
                        qr_d  = booth_q;
                        qm1_d = qr_q[0];
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            hi_d    = booth_acc[W-1:0];
                            lo_d    = booth_q;
                            dbz_d   = 1'b0;
                            state_d = DONE;
                        end
                    end
                    OP_DIV: begin
                        if (d_q == '0) begin
                            hi_d    = m_q;
                            lo_d    = '1;
                            dbz_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            acc_d = div_r;
                            qr_d  = div_q;
                            cnt_d = cnt_q + 1'b1;
                            if (cnt_q == LAST) begin
                                hi_d    = div_r[W-1:0];
                                lo_d    = div_q;
                                dbz_d   = 1'b0;
                                state_d = DONE;
                            end
                        end
                    end
                    default: begin
                        hi_d    = {W{addsub[W]}};
                        lo_d    = addsub[W-1:0];
                        dbz_d   = 1'b0;
                        state_d = DONE;
                    end
                endcase
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign res_hi      = hi_q;
    assign res_lo      = lo_q;
    assign div_by_zero = dbz_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at W=8: handshake latency, arithmetic results,
// backpressure, mid-operation reset and back-to-back throughput.
module tb_seq_alu;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] op = 2'd0;
    logic [7:0] a_in = 8'd0;
    logic [7:0] b_in = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] res_hi, res_lo;
    logic       div_by_zero, busy;
    logic [1:0] state_o;

    int checks = 0;
    int fails  = 0;

    seq_alu #(.W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
        .res_hi(res_hi), .res_lo(res_lo), .div_by_zero(div_by_zero), .busy(busy),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one op, then waits (bounded) for out_valid; lat counts edges after the accept edge.
    task automatic run_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                          input bit noise, output int lat);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        op = o; a_in = a; b_in = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = noise;
        op = 2'($urandom); a_in = 8'($urandom); b_in = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
            if (noise) begin
                op = 2'($urandom); a_in = 8'($urandom); b_in = 8'($urandom);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl got in_ready=%b out_valid=%b busy=%b exp 1 0 0", in_ready, out_valid, busy);
        end
        checks++;
        if (res_hi !== 8'h00 || res_lo !== 8'h00 || div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL reset_data got hi=%h lo=%h dbz=%b exp 00 00 0", res_hi, res_lo, div_by_zero);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_addsub();
        logic [1:0] vo [4] = '{2'd0, 2'd1, 2'd1, 2'd0};
        logic [7:0] va [4] = '{8'h7F, 8'h00, 8'h80, 8'h80};
        logic [7:0] vb [4] = '{8'h01, 8'h01, 8'h7F, 8'h80};
        logic [7:0] eh [4] = '{8'h00, 8'hFF, 8'hFF, 8'hFF};
        logic [7:0] el [4] = '{8'h80, 8'hFF, 8'h01, 8'h00};
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(vo[i], va[i], vb[i], 1'b0, lat);
            checks++;
            if (lat !== 1) begin
                fails++;
                $display("FAIL addsub_lat[%0d] got %0d exp 1", i, lat);
            end
            checks++;
            if (res_hi !== eh[i] || res_lo !== el[i] || div_by_zero !== 1'b0) begin
                fails++;
                $display("FAIL addsub_res[%0d] got %h_%h dbz=%b exp %h_%h dbz=0", i, res_hi, res_lo, div_by_zero, eh[i], el[i]);
            end
            drain();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL addsub_drain[%0d] got out_valid=%b in_ready=%b exp 0 1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_mul();
        logic [7:0] va [5] = '{8'hFD, 8'h80, 8'h7F, 8'h80, 8'h05};
        logic [7:0] vb [5] = '{8'h07, 8'h80, 8'h7F, 8'h7F, 8'hFB};
        logic [7:0] eh [5] = '{8'hFF, 8'h40, 8'h3F, 8'hC0, 8'hFF};
        logic [7:0] el [5] = '{8'hEB, 8'h00, 8'h01, 8'h80, 8'hE7};
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(2'd2, va[i], vb[i], 1'b0, lat);
            checks++;
            if (lat !== 8) begin
                fails++;
                $display("FAIL mul_lat[%0d] got %0d exp 8", i, lat);
            end
            checks++;
            if (res_hi !== eh[i] || res_lo !== el[i] || div_by_zero !== 1'b0) begin
                fails++;
                $display("FAIL mul_res[%0d] got %h_%h dbz=%b exp %h_%h dbz=0", i, res_hi, res_lo, div_by_zero, eh[i], el[i]);
            end
            drain();
        end
    endtask

    task automatic test_div();
        logic [7:0] va [5] = '{8'd200, 8'hFF, 8'h05, 8'hFF, 8'h2A};
        logic [7:0] vb [5] = '{8'd7,   8'h01, 8'h09, 8'h10, 8'h00};
        logic [7:0] eh [5] = '{8'h04,  8'h00, 8'h05, 8'h0F, 8'h2A};
        logic [7:0] el [5] = '{8'h1C,  8'hFF, 8'h00, 8'h0F, 8'hFF};
        int         el_lat [5] = '{8, 8, 8, 8, 1};
        logic       ed [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(2'd3, va[i], vb[i], 1'b0, lat);
            checks++;
            if (lat !== el_lat[i]) begin
                fails++;
                $display("FAIL div_lat[%0d] got %0d exp %0d", i, lat, el_lat[i]);
            end
            checks++;
            if (res_hi !== eh[i] || res_lo !== el[i] || div_by_zero !== ed[i]) begin
                fails++;
                $display("FAIL div_res[%0d] got %h_%h dbz=%b exp %h_%h dbz=%b", i, res_hi, res_lo, div_by_zero, eh[i], el[i], ed[i]);
            end
            drain();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(2'd0, 8'h10, 8'h20, 1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            op = 2'd2; a_in = 8'($urandom); b_in = 8'($urandom); in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || res_hi !== 8'h00 || res_lo !== 8'h30) begin
                fails++;
                $display("FAIL hold[%0d] got v=%b rdy=%b %h_%h exp 1 0 00_30", i, out_valid, in_ready, res_hi, res_lo);
            end
        end
        in_valid = 1'b0;
        drain();
        run_op(2'd2, 8'h03, 8'h04, 1'b1, lat);
        checks++;
        if (lat !== 8 || res_hi !== 8'h00 || res_lo !== 8'h0C) begin
            fails++;
            $display("FAIL busy_ignore got lat=%0d %h_%h exp 8 00_0C", lat, res_hi, res_lo);
        end
        drain();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        op = 2'd2; a_in = 8'h7F; b_in = 8'h7F; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || res_hi !== 8'h00 || res_lo !== 8'h00) begin
            fails++;
            $display("FAIL mid_reset got busy=%b rdy=%b v=%b %h_%h exp 0 1 0 00_00", busy, in_ready, out_valid, res_hi, res_lo);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL stale[%0d] got out_valid=%b busy=%b exp 0 0", i, out_valid, busy);
            end
        end
        run_op(2'd0, 8'h11, 8'h22, 1'b0, lat);
        checks++;
        if (lat !== 1 || res_hi !== 8'h00 || res_lo !== 8'h33) begin
            fails++;
            $display("FAIL post_reset_add got lat=%0d %h_%h exp 1 00_33", lat, res_hi, res_lo);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        op = 2'd0; a_in = 8'h01; b_in = 8'h02; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            checks++;
            if (in_ready !== (i % 3 == 0) || out_valid !== (i % 3 == 2)) begin
                fails++;
                $display("FAIL b2b_hs[%0d] got rdy=%b v=%b exp %b %b", i, in_ready, out_valid, (i % 3 == 0), (i % 3 == 2));
            end
            if (i % 3 == 2) begin
                checks++;
                if (res_lo !== 8'h03 || res_hi !== 8'h00) begin
                    fails++;
                    $display("FAIL b2b_res[%0d] got %h_%h exp 00_03", i, res_hi, res_lo);
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_addsub();
        test_mul();
        test_div();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
